// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad decoder with frame-based debounce and press/release events
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   col_n        raw active-low column sense, asynchronous to clk
//   row_drv_n    one-hot active-low row drive
//   key_valid    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when the held key is released
//   key_held     high while an accepted key is down
//   key_idx      linear index row*COLS+col of the held or last key
//   key_row      row of the held or last key
//   key_col      column of the held or last key
//   hex_digit    launchpad legend of the key (0 when HEX_MAP=0)
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int HEX_MAP         = 1
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [COLS-1:0]                                     col_n,
    output logic [ROWS-1:0]                                     row_drv_n,
    output logic                                                key_valid,
    output logic                                                key_release,
    output logic                                                key_held,
    output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] key_idx,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]           key_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]           key_col,
    output logic [3:0]                                          hex_digit
);
    localparam int IW = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} state_t;

    logic [COLS-1:0] r_sync1, r_sync2;
    logic [SW-1:0]   r_slot;
    logic [RW-1:0]   r_row;
    logic [1:0]      r_acc_n;
    logic [RW-1:0]   r_acc_row;
    logic [CW-1:0]   r_acc_col;
    state_t          r_state;
    logic [RW-1:0]   r_cand_row;
    logic [CW-1:0]   r_cand_col;
    logic [DW-1:0]   r_cnt;
    logic            r_valid, r_release;
    logic [IW-1:0]   r_key_idx;
    logic [RW-1:0]   r_key_row;
    logic [CW-1:0]   r_key_col;
    logic [3:0]      r_hex;

    logic [COLS-1:0] w_col;
    logic            w_sample, w_frame_end;
    logic [1:0]      w_ones;
    logic [CW-1:0]   w_pos;
    logic [2:0]      w_sum;
    logic [1:0]      w_tot;
    logic [RW-1:0]   w_k_row;
    logic [CW-1:0]   w_k_col;
    logic            w_none, w_one, w_same;
    logic [DW:0]     w_cnt_inc;
    logic            w_cnt_done;
    state_t          w_state_nxt;
    logic [RW-1:0]   w_cand_row_nxt;
    logic [CW-1:0]   w_cand_col_nxt;
    logic [DW-1:0]   w_cnt_nxt;
    logic            w_accept, w_release;
    logic [IW-1:0]   w_cand_idx;
    logic [3:0]      w_hex;

    assign w_col       = ~r_sync2;
    assign w_sample    = r_slot == SW'(SCAN_DIV - 1);
    assign w_frame_end = w_sample && (r_row == RW'(ROWS - 1));
    assign row_drv_n   = ~(ROWS'(1) << r_row);

    // Per-row key count saturates at 2: anything above one key is MULTI.
    always_comb begin
        w_ones = 2'd0;
        w_pos  = '0;
        for (int c = 0; c < COLS; c++)
            if (w_col[c]) begin
                w_ones = (w_ones == 2'd2) ? 2'd2 : w_ones + 2'd1;
                w_pos  = CW'(c);
            end
    end

    // Frame result including the row being sampled this cycle.
    assign w_sum   = {1'b0, r_acc_n} + {1'b0, w_ones};
    assign w_tot   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_k_row = (r_acc_n == 2'd0) ? r_row : r_acc_row;
    assign w_k_col = (r_acc_n == 2'd0) ? w_pos : r_acc_col;
    assign w_none  = w_tot == 2'd0;
    assign w_one   = w_tot == 2'd1;
    assign w_same  = (w_k_row == r_cand_row) && (w_k_col == r_cand_col);

    assign w_cnt_inc  = {1'b0, r_cnt} + (DW+1)'(1);
    assign w_cnt_done = w_cnt_inc >= (DW+1)'(DEBOUNCE_FRAMES);

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_row_nxt = r_cand_row;
        w_cand_col_nxt = r_cand_col;
        w_cnt_nxt      = r_cnt;
        w_accept       = 1'b0;
        w_release      = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                IDLE:
                    if (w_one) begin
                        w_cand_row_nxt = w_k_row;
                        w_cand_col_nxt = w_k_col;
                        w_cnt_nxt      = DW'(1);
                        w_state_nxt    = CONFIRM_PRESS;
                        w_accept       = (DEBOUNCE_FRAMES == 1);
                    end
                CONFIRM_PRESS:
                    if (w_one && w_same) begin
                        w_cnt_nxt = w_cnt_inc[DW-1:0];
                        w_accept  = w_cnt_done;
                    end else if (w_one) begin
                        w_cand_row_nxt = w_k_row;
                        w_cand_col_nxt = w_k_col;
                        w_cnt_nxt      = DW'(1);
                    end else
                        w_state_nxt = IDLE;
                // A different single key while held counts as an empty frame.
                HELD:
                    if (!(w_one && w_same) && (w_tot != 2'd2)) begin
                        w_cnt_nxt   = DW'(1);
                        w_state_nxt = CONFIRM_RELEASE;
                        w_release   = (DEBOUNCE_FRAMES == 1);
                    end
                CONFIRM_RELEASE:
                    if (w_none) begin
                        w_cnt_nxt = w_cnt_inc[DW-1:0];
                        w_release = w_cnt_done;
                    end else
                        w_state_nxt = HELD;
                default: w_state_nxt = IDLE;
            endcase
            if (w_accept)
                w_state_nxt = HELD;
            if (w_release)
                w_state_nxt = IDLE;
        end
    end

    assign w_cand_idx = IW'(w_cand_row_nxt) * IW'(COLS) + IW'(w_cand_col_nxt);

    generate
        if (HEX_MAP == 1 && ROWS == 4 && COLS == 4) begin : g_hex
            // Nibble n holds the legend of linear key n.
            localparam logic [63:0] HEX_LUT = 64'hDEF0_C987_B654_A321;
            assign w_hex = HEX_LUT[{w_cand_idx, 2'b00} +: 4];
        end else begin : g_nohex
            assign w_hex = 4'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_slot    <= '0;
            r_row     <= '0;
            r_acc_n   <= '0;
            r_acc_row <= '0;
            r_acc_col <= '0;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
            r_slot  <= w_sample ? '0 : r_slot + SW'(1);
            if (w_sample)
                r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
            if (w_frame_end) begin
                r_acc_n   <= '0;
                r_acc_row <= '0;
                r_acc_col <= '0;
            end else if (w_sample) begin
                r_acc_n   <= w_tot;
                r_acc_row <= w_k_row;
                r_acc_col <= w_k_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cand_row <= '0;
            r_cand_col <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_release  <= 1'b0;
            r_key_idx  <= '0;
            r_key_row  <= '0;
            r_key_col  <= '0;
            r_hex      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand_row <= w_cand_row_nxt;
            r_cand_col <= w_cand_col_nxt;
            r_cnt      <= w_cnt_nxt;
            r_valid    <= w_accept;
            r_release  <= w_release;
            if (w_accept) begin
                r_key_idx <= w_cand_idx;
                r_key_row <= w_cand_row_nxt;
                r_key_col <= w_cand_col_nxt;
                r_hex     <= w_hex;
            end
        end
    end

    assign key_valid   = r_valid;
    assign key_release = r_release;
    assign key_held    = (r_state == HELD) || (r_state == CONFIRM_RELEASE);
    assign key_idx     = r_key_idx;
    assign key_row     = r_key_row;
    assign key_col     = r_key_col;
    assign hex_digit   = r_hex;
endmodule
